uart_rx_framed: RTL and testbench

Parametrised UART receive engine and the next generation of the current receiver. It is configurable in data width, parity mode and stop-bit count. It adds input synchronisation, start-bit glitch rejection, 3-sample majority voting, parity and framing error detection, and a valid/ack output handshake with overrun detection. It sits behind the Rx pin in the UART top and feeds the host-side read path.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_framed_if.sv | 24 ++
 rtl/uart_rx_sampler.sv | 41 ++++
 rtl/uart_rx_framed.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_framed.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, receiver state encoding and a
// small majority-vote helper used by the receive sampler.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_framed_if.sv
// Host-facing signal bundle of the framed UART receiver: serial input,
// read handshake and the held-frame status flags.
interface uart_rx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic                 Rx;
    logic                 rd_ack;
    logic [DATA_BITS-1:0] data;
    logic                 R_rdy;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output Rx, rd_ack,
        input  data, R_rdy, parity_err, frame_err, overrun, busy
    );

    modport slave (
        input  Rx, rd_ack,
        output data, R_rdy, parity_err, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Rx front end: two-flop synchroniser, previous-line flop for edge detection,
// and two stored samples that combine with the live line into a 3-way vote.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    input  logic i_strobe,
    output logic o_line,
    output logic o_line_prev,
    output logic o_majority
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_line_prev;
    logic [1:0] r_samples;

    // Idle-high reset values keep a reset release from looking like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_line_prev <= 1'b1;
            r_samples   <= 2'b11;
        end else begin
            r_sync1     <= i_rx;
            r_sync2     <= r_sync1;
            r_line_prev <= r_sync2;
            if (i_strobe) begin
                r_samples <= {r_samples[0], r_sync2};
            end
        end
    end

    assign o_line      = r_sync2;
    assign o_line_prev = r_line_prev;
    assign o_majority  = majority3(r_samples[1], r_samples[0], r_sync2);

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receive engine with glitch rejection, majority-voted bits,
// parity/framing checks and a valid/ack holding register with overrun flag.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 435,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_rx_framed_if.slave bus
);

    localparam int CW = $clog2(CLKS_PER_BIT + 2);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] SAMP_A    = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] SAMP_B    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SAMP_C    = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 8) begin : g_chk_cpb
        $error("uart_rx_framed: CLKS_PER_BIT must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
        $error("uart_rx_framed: DATA_BITS must be in 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_chk_par
        $error("uart_rx_framed: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_rx_framed: STOP_BITS must be 1 or 2");
    end

    rx_state_t            r_state;
    rx_state_t            w_state_next;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr_acc;
    logic                 r_ferr_acc;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_rdy;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_overrun;

    logic w_line;
    logic w_line_prev;
    logic w_bit;
    logic w_in_bit;
    logic w_strobe;
    logic w_bit_done;
    logic w_commit;
    logic w_frame_err_next;
    logic w_exp_parity;

    uart_rx_sampler u_sampler (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx        (bus.Rx),
        .i_strobe    (w_strobe),
        .o_line      (w_line),
        .o_line_prev (w_line_prev),
        .o_majority  (w_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RX_IDLE:      if (!w_line && w_line_prev) w_state_next = RX_START;
            RX_START:     if (r_cnt == HALF_M1) w_state_next = w_line ? RX_IDLE : RX_DATA;
            RX_DATA:      if (w_bit_done && r_bit_cnt == LAST_DATA)
                              w_state_next = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (w_bit_done) w_state_next = RX_STOP;
            RX_STOP:      if (w_commit) w_state_next = w_bit ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (w_line) w_state_next = RX_IDLE;
            default:      w_state_next = RX_IDLE;
        endcase
    end

    // Samples land at C-1 and C; the C+1 edge votes with the live line and closes the bit.
    always_comb begin
        w_in_bit         = (r_state == RX_DATA) || (r_state == RX_PARITY) || (r_state == RX_STOP);
        w_strobe         = w_in_bit && ((r_cnt == SAMP_A) || (r_cnt == SAMP_B));
        w_bit_done       = w_in_bit && (r_cnt == SAMP_C);
        w_commit         = (r_state == RX_STOP) && w_bit_done && (r_bit_cnt == LAST_STOP);
        w_frame_err_next = r_ferr_acc | ~w_bit;
        w_exp_parity     = (PARITY == PAR_ODD) ? ~(^r_shift) : (^r_shift);
    end

    // Bit timer restarts at 1 after C+1 so every bit spans exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
        end else begin
            case (r_state)
                RX_START:                    r_cnt <= (r_cnt == HALF_M1) ? '0 : r_cnt + CNT_ONE;
                RX_DATA, RX_PARITY, RX_STOP: r_cnt <= w_bit_done ? CNT_ONE : r_cnt + CNT_ONE;
                default:                     r_cnt <= '0;
            endcase

            if (r_state == RX_IDLE) begin
                r_bit_cnt  <= '0;
                r_perr_acc <= 1'b0;
                r_ferr_acc <= 1'b0;
            end else if (w_bit_done) begin
                case (r_state)
                    RX_DATA: begin
                        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= (r_bit_cnt == LAST_DATA) ? '0 : r_bit_cnt + BIT_ONE;
                    end
                    RX_PARITY: r_perr_acc <= (w_bit != w_exp_parity);
                    RX_STOP: begin
                        r_ferr_acc <= w_frame_err_next;
                        r_bit_cnt  <= r_bit_cnt + BIT_ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A commit coinciding with an ack replaces the held frame instead of overrunning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_rdy     <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_commit) begin
            if (!r_rdy || bus.rd_ack) begin
                r_data <= r_shift;
                r_perr <= r_perr_acc;
                r_ferr <= w_frame_err_next;
                r_rdy  <= 1'b1;
                if (bus.rd_ack) begin
                    r_overrun <= 1'b0;
                end
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (bus.rd_ack && r_rdy) begin
            r_rdy     <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign bus.data       = r_data;
    assign bus.R_rdy      = r_rdy;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.overrun    = r_overrun;
    assign bus.busy       = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed at 16 clocks/bit, 8 data bits, even parity,
// one stop bit: a vector table of whole frames plus hand-built corner sequences.
module tb_uart_rx_framed;
    import uart_pkg::*;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] dIn;
        logic       parIn;
        logic       stopIn;
        logic [7:0] expData;
        logic       expPerr;
        logic       expFerr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic sawRdy;
    vec_t vecs[8];

    uart_rx_framed_if #(.DATA_BITS(8)) bus ();

    uart_rx_framed #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY       (PAR_EVEN),
        .STOP_BITS    (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Every driving task starts and ends 1 time unit after a rising edge.
    task automatic holdRx(input logic v, input int n);
        bus.Rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stp, input int glitchBit);
        logic [10:0] frame;
        frame = {stp, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (i == glitchBit) begin
                holdRx(frame[i], 8);
                holdRx(~frame[i], 1);
                holdRx(frame[i], 7);
            end else begin
                holdRx(frame[i], CPB);
            end
        end
    endtask

    task automatic ackPulse();
        bus.rd_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_ack = 1'b0;
    endtask

    task automatic watchNoRdy(input int n);
        sawRdy = 1'b0;
        for (int k = 0; k < n; k++) begin
            holdRx(1'b1, 1);
            if (bus.R_rdy) sawRdy = 1'b1;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hA9, 1'b0, 1'b1, 8'hA9, 1'b0, 1'b0};
        vecs[1] = '{8'hA9, 1'b1, 1'b1, 8'hA9, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[6] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[7] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};

        bus.Rx     = 1'b1;
        bus.rd_ack = 1'b0;
        rst_n      = 1'b1;
        #2 rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset R_rdy", 32'(bus.R_rdy), 0);
        checkOutput("reset data", 32'(bus.data), 0);
        checkOutput("reset busy", 32'(bus.busy), 0);
        checkOutput("reset overrun", 32'(bus.overrun), 0);
        checkOutput("reset parity_err", 32'(bus.parity_err), 0);
        checkOutput("reset frame_err", 32'(bus.frame_err), 0);
        rst_n = 1'b1;
        holdRx(1'b1, 4);

        // R_rdy must rise on exactly cycle 171 counted from the first low sample.
        fork
            applyStimulus(8'hA9, 1'b0, 1'b1, -1);
            begin
                repeat (171) @(posedge clk);
                #1;
                checkOutput("timing R_rdy at cycle 170", 32'(bus.R_rdy), 0);
                @(posedge clk);
                #1;
                checkOutput("timing R_rdy at cycle 171", 32'(bus.R_rdy), 1);
                checkOutput("timing busy at cycle 171", 32'(bus.busy), 0);
            end
        join
        holdRx(1'b1, 4);
        checkOutput("timing data", 32'(bus.data), 32'h A9);
        checkOutput("timing parity_err", 32'(bus.parity_err), 0);
        checkOutput("timing frame_err", 32'(bus.frame_err), 0);
        ackPulse();
        checkOutput("timing R_rdy after ack", 32'(bus.R_rdy), 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].dIn, vecs[i].parIn, vecs[i].stopIn, -1);
            holdRx(1'b1, 6);
            checkOutput($sformatf("vec%0d R_rdy", i), 32'(bus.R_rdy), 1);
            checkOutput($sformatf("vec%0d data", i), 32'(bus.data), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d parity_err", i), 32'(bus.parity_err), 32'(vecs[i].expPerr));
            checkOutput($sformatf("vec%0d frame_err", i), 32'(bus.frame_err), 32'(vecs[i].expFerr));
            checkOutput($sformatf("vec%0d overrun", i), 32'(bus.overrun), 0);
            checkOutput($sformatf("vec%0d busy", i), 32'(bus.busy), 0);
            ackPulse();
            checkOutput($sformatf("vec%0d R_rdy after ack", i), 32'(bus.R_rdy), 0);
            checkOutput($sformatf("vec%0d flags after ack", i),
                        32'({bus.parity_err, bus.frame_err}), 0);
        end

        // Break condition: stop bit low and the line held low afterwards.
        applyStimulus(8'h3C, 1'b0, 1'b0, -1);
        holdRx(1'b0, 40);
        checkOutput("break R_rdy", 32'(bus.R_rdy), 1);
        checkOutput("break data", 32'(bus.data), 32'h3C);
        checkOutput("break frame_err", 32'(bus.frame_err), 1);
        checkOutput("break busy while low", 32'(bus.busy), 1);
        ackPulse();
        holdRx(1'b0, 20);
        checkOutput("break busy still low", 32'(bus.busy), 1);
        checkOutput("break R_rdy after ack", 32'(bus.R_rdy), 0);
        holdRx(1'b1, 5);
        checkOutput("break busy after release", 32'(bus.busy), 0);
        watchNoRdy(200);
        checkOutput("break no second frame", 32'(sawRdy), 0);

        // Short low pulse must be rejected as a glitch.
        holdRx(1'b0, 5);
        checkOutput("pulse busy during pulse", 32'(bus.busy), 1);
        holdRx(1'b1, 8);
        checkOutput("pulse busy after reject", 32'(bus.busy), 0);
        watchNoRdy(200);
        checkOutput("pulse no frame", 32'(sawRdy), 0);

        applyStimulus(8'h55, 1'b0, 1'b1, 4);
        holdRx(1'b1, 4);
        checkOutput("glitch R_rdy", 32'(bus.R_rdy), 1);
        checkOutput("glitch data", 32'(bus.data), 32'h55);
        checkOutput("glitch parity_err", 32'(bus.parity_err), 0);
        checkOutput("glitch frame_err", 32'(bus.frame_err), 0);
        ackPulse();

        applyStimulus(8'h11, 1'b0, 1'b1, -1);
        applyStimulus(8'h22, 1'b0, 1'b1, -1);
        holdRx(1'b1, 4);
        checkOutput("overrun data kept", 32'(bus.data), 32'h11);
        checkOutput("overrun flag", 32'(bus.overrun), 1);
        checkOutput("overrun R_rdy", 32'(bus.R_rdy), 1);
        ackPulse();
        checkOutput("overrun R_rdy after ack", 32'(bus.R_rdy), 0);
        checkOutput("overrun cleared by ack", 32'(bus.overrun), 0);

        applyStimulus(8'h11, 1'b0, 1'b1, -1);
        fork
            applyStimulus(8'h22, 1'b0, 1'b1, -1);
            begin
                repeat (171) @(posedge clk);
                #1 bus.rd_ack = 1'b1;
                @(posedge clk);
                #1 bus.rd_ack = 1'b0;
            end
        join
        holdRx(1'b1, 4);
        checkOutput("ack+commit data", 32'(bus.data), 32'h22);
        checkOutput("ack+commit overrun", 32'(bus.overrun), 0);
        checkOutput("ack+commit R_rdy", 32'(bus.R_rdy), 1);

        // Reset asserted during data bit 4 while a frame is still held.
        fork
            applyStimulus(8'hF8, 1'b1, 1'b1, -1);
            begin
                repeat (88) @(posedge clk);
                #1;
                checkOutput("midreset busy before", 32'(bus.busy), 1);
                rst_n = 1'b0;
                #1;
                checkOutput("midreset R_rdy", 32'(bus.R_rdy), 0);
                checkOutput("midreset data", 32'(bus.data), 0);
                checkOutput("midreset busy", 32'(bus.busy), 0);
                checkOutput("midreset flags",
                            32'({bus.overrun, bus.parity_err, bus.frame_err}), 0);
                repeat (5) @(posedge clk);
                #1;
                checkOutput("midreset busy held", 32'(bus.busy), 0);
                checkOutput("midreset data held", 32'(bus.data), 0);
                rst_n = 1'b1;
            end
        join
        watchNoRdy(30);
        checkOutput("postreset no spurious R_rdy", 32'(sawRdy), 0);
        applyStimulus(8'hC3, 1'b0, 1'b1, -1);
        holdRx(1'b1, 4);
        checkOutput("postreset R_rdy", 32'(bus.R_rdy), 1);
        checkOutput("postreset data", 32'(bus.data), 32'hC3);
        checkOutput("postreset parity_err", 32'(bus.parity_err), 0);
        checkOutput("postreset frame_err", 32'(bus.frame_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
